led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Downstream consumer of the Qsys system's `led_pio_export[7:0]` PIO output. It turns each on/off request bit into a smooth PWM brightness fade on the corresponding board LED. It sits between the system top-level export and the LED pins, and runs in the same `clk_clk` domain as the PIO. A bypass mode passes the PIO bits straight through.

## Interface
- `PWM_BITS`, default 8: brightness resolution; `PWM_MAX` = 2^PWM_BITS−1.
- `FADE_DIV`, default 19531: `clk_clk` cycles per brightness step. At 50 MHz, a full ramp takes about 100 ms.
- `LED_COUNT`, default 8: number of channels.
- `clk_clk`  in  1  system clock; every register is on its rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `led_pio_export`  in  LED_COUNT  per-LED on/off request from the PIO, synchronous to `clk_clk`.
- `enable`  in  1  1 = fade mode, 0 = bypass.
- `led_out`  out  LED_COUNT  LED pin drive, registered.
- `busy`  out  1  registered; 1 while any channel is ramping.

## Operation
- **Request register:** `led_pio_export` is registered once into `req_q`.
- **Prescaler:** counts 0..FADE_DIV−1 and wraps. `tick` is a 1-cycle pulse in the cycle the prescaler equals FADE_DIV−1.
- **PWM counter:** `pwm_cnt` free-runs 0..PWM_MAX−1 and wraps, so the period is PWM_MAX cycles.
- **Per-channel FSM:** states OFF, RISE, ON, FALL, with a level register of PWM_BITS.
  - OFF→RISE when `req_q`=1.
  - ON→FALL when `req_q`=0.
  - RISE→FALL when `req_q`=0, and FALL→RISE when `req_q`=1. Reversal continues from the current level with no jump.
  - In RISE, on `tick`: level+1. When the level reaches PWM_MAX, go to ON.
  - In FALL, on `tick`: level−1. When the level reaches 0, go to OFF.
  - The level saturates and never wraps.
- **Simultaneous events:** when a request change and a `tick` occur in the same cycle, the state change applies first, then the step in the new direction in that same cycle.
- **Output:** `led_out[i]` = (level[i] > `pwm_cnt`).
  - Level 0 gives constant 0.
  - Level PWM_MAX gives constant 1.
  - Level L gives L high cycles per period.
- **busy:** OR over channels of (state ∈ {RISE, FALL}).
- **Bypass (`enable`=0):**
  - Prescaler and `pwm_cnt` are held at 0.
  - Each channel snaps to ON with level PWM_MAX if `req_q`=1, otherwise to OFF with level 0.
  - `led_out` = `req_q`.
  - `busy` = 0.
- **Returning to `enable`=1:** resumes from the snapped levels, with no glitch on `led_out`.

## Timing
- **Reset values:** `led_out`=0 and `busy`=0. Internally: `req_q`=0, all levels 0, all states OFF, prescaler 0, `pwm_cnt` 0.
- **Reset mid-operation:** reset is asynchronous, so outputs clear in the same cycle, independent of the clock.
- **Request to state latency:** a request change at edge N reaches `req_q` at N+1 and the state at N+2. `busy` rises at N+3.
- **Bypass latency:** `led_out` follows `led_pio_export` 2 cycles later.
- **Full ramp:** PWM_MAX ticks, i.e. PWM_MAX×FADE_DIV cycles, ±1 tick of phase.

## Structure
- **Package `led_fader_pkg`:** holds the channel state enum (OFF, RISE, ON, FALL) and a function computing `PWM_MAX` from `PWM_BITS`.
- **Sub-module `led_fade_channel`:**
  - Contains the FSM, the level register, and the PWM compare.
  - Inputs: `clk_clk`, `reset_reset_n`, `req`, `tick`, `pwm_cnt`, `enable`.
  - Outputs: `led`, `ramping`.
  - Instantiated LED_COUNT times via generate.
- **Top:** holds the request register, prescaler, PWM counter, and the `busy` OR.

## Test plan
All scenarios use `FADE_DIV`=4, `PWM_BITS`=8.
- **Reset:** assert `reset_reset_n`=0 with `led_pio_export`=8'hFF → `led_out`=8'h00, `busy`=0 for the whole reset.
- **Rise:** `enable`=1, `led_pio_export` 8'h00→8'h01 → `busy`=1 three cycles later. Level 255 is reached after 255 ticks (1020±4 cycles). `led_out[0]` is then constant 1 and `busy`=0.
- **Duty:** hold channel 0 at level 128 with `tick` forced low → `led_out[0]` is high for exactly 128 of each 255-cycle period.
- **Reversal:** drop the request when level = 100 → level goes 100→0 in 100 ticks with no step above 100. Channel ends in OFF with `led_out[0]`=0.
- **Bypass:** `enable`=0, `led_pio_export`=8'hA5 → `led_out`=8'hA5 two cycles later, `busy`=0. Re-enable → `led_out` stays 8'hA5 with no 0 pulses.
- **Async reset:** assert reset mid-ramp at level 60 → `led_out`=0 with no clock edge needed. After release, the channel restarts from 0 and reaches 255 after 255 ticks.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED PWM fader: channel state encoding
// and the full-brightness level derived from the PWM resolution.
package led_fader_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_e;

  // Full-brightness level for a given PWM resolution.
  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, saturating brightness level and registered
// PWM compare; in bypass it snaps to full on or full off.
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                req,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                enable,
  output logic                led,
  output logic                ramping
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(pwm_max(PWM_BITS));

  fade_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;

  // Direction changes resolve first, then a tick steps in the new direction.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    led_d   = req;
    if (!enable) begin
      state_d = req ? ST_ON : ST_OFF;
      level_d = req ? LVL_MAX : '0;
    end else begin
      led_d = (level_q > pwm_cnt);
      case (state_q)
        ST_OFF:  if (req)  state_d = ST_RISE;
        ST_RISE: if (!req) state_d = ST_FALL;
        ST_ON:   if (!req) state_d = ST_FALL;
        ST_FALL: if (req)  state_d = ST_RISE;
        default: state_d = ST_OFF;
      endcase
      if (tick) begin
        if (state_d == ST_RISE && level_q != LVL_MAX) begin
          level_d = level_q + PWM_BITS'(1);
        end else if (state_d == ST_FALL && level_q != '0) begin
          level_d = level_q - PWM_BITS'(1);
        end
      end
      if (state_d == ST_RISE && level_d == LVL_MAX) begin
        state_d = ST_ON;
      end else if (state_d == ST_FALL && level_d == '0) begin
        state_d = ST_OFF;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_OFF;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led     = led_q;
  assign ramping = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: rtl/led_pwm_fader.sv
// Turns PIO on/off bits into PWM brightness fades per LED; request register,
// fade prescaler, shared PWM counter and the aggregate busy flag live here.
module led_pwm_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_DIV  = 19531,
  parameter int unsigned LED_COUNT = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [LED_COUNT-1:0] led_pio_export,
  input  logic                 enable,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 busy
);

  localparam int unsigned          PRESC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0]  CNT_LAST   = PWM_BITS'(pwm_max(PWM_BITS) - 1);

  logic [LED_COUNT-1:0] req_q, req_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 busy_q, busy_d;
  logic                 tick_c;
  logic [LED_COUNT-1:0] ramping_c;
  logic [LED_COUNT-1:0] led_c;

  assign tick_c = enable && (presc_q == PRESC_LAST);

  // Bypass parks both counters at zero so re-enabling starts a clean period.
  always_comb begin
    req_d     = led_pio_export;
    presc_d   = '0;
    pwm_cnt_d = '0;
    busy_d    = 1'b0;
    if (enable) begin
      presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
      busy_d    = |ramping_c;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar i = 0; i < int'(LED_COUNT); i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .req          (req_q[i]),
      .tick         (tick_c),
      .pwm_cnt      (pwm_cnt_q),
      .enable       (enable),
      .led          (led_c[i]),
      .ramping      (ramping_c[i])
    );
  end

  assign led_out = led_c;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with FADE_DIV=4, PWM_BITS=8: reset, rise,
// duty, reversal, bypass and asynchronous reset scenarios.
module tb_led_pwm_fader;
  import led_fader_pkg::*;

  localparam int unsigned PWM_BITS  = 8;
  localparam int unsigned FADE_DIV  = 4;
  localparam int unsigned LED_COUNT = 8;

  logic                 clk_clk = 1'b0;
  logic                 reset_reset_n = 1'b1;
  logic [LED_COUNT-1:0] led_pio_export = '0;
  logic                 enable = 1'b1;
  logic [LED_COUNT-1:0] led_out;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  lvl0;
  fade_state_e st0;

  led_pwm_fader #(
    .PWM_BITS (PWM_BITS),
    .FADE_DIV (FADE_DIV),
    .LED_COUNT(LED_COUNT)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .led_pio_export(led_pio_export),
    .enable        (enable),
    .led_out       (led_out),
    .busy          (busy)
  );

  assign lvl0 = dut.g_ch[0].u_ch.level_q;
  assign st0  = dut.g_ch[0].u_ch.state_q;

  always #5 clk_clk = ~clk_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int cnt;
    int cnt2;
    int maxl;
    int ups;
    int downs;
    int prev;

    // Reset with all requests high
    #1;
    reset_reset_n  = 1'b0;
    led_pio_export = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_eq("rst_led_out", 32'(led_out), 32'h00);
      check_eq("rst_busy", 32'(busy), 0);
    end
    led_pio_export = 8'h00;
    reset_reset_n  = 1'b1;
    step(3);

    // Rise on channel 0
    led_pio_export = 8'h01;
    step(2);
    check_eq("rise_busy_n2", 32'(busy), 0);
    step(1);
    check_eq("rise_busy_n3", 32'(busy), 1);
    cyc = 1;
    while (lvl0 != 8'd255 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    check_eq("rise_ramp_cycles_in_1016_1019", 32'(cyc >= 1016 && cyc <= 1019), 1);
    step(1);
    check_eq("rise_busy_done", 32'(busy), 0);
    check_eq("rise_state_on", 32'(st0), 32'(ST_ON));
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (led_out[0] !== 1'b1) cnt++;
      if (led_out[7:1] !== 7'd0) cnt++;
    end
    check_eq("rise_full_on_lows", 32'(cnt), 0);

    // Fall to 128 and freeze the level to measure duty
    led_pio_export = 8'h00;
    cyc = 0;
    while (lvl0 != 8'd128 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    force dut.tick_c = 1'b0;
    step(3);
    check_eq("duty_level_held", 32'(lvl0), 128);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (led_out[0] === 1'b1) cnt++;
    end
    check_eq("duty_high_per_period_1", 32'(cnt), 128);
    cnt2 = 0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (led_out[0] === 1'b1) cnt2++;
    end
    check_eq("duty_high_per_period_2", 32'(cnt2), 128);
    check_eq("duty_busy_frozen_fall", 32'(busy), 1);
    release dut.tick_c;

    // Finish falling, then rise to 100 and reverse
    cyc = 0;
    while (st0 != ST_OFF && cyc < 2000) begin
      step(1);
      cyc++;
    end
    check_eq("rev_pre_level_zero", 32'(lvl0), 0);
    led_pio_export = 8'h01;
    cyc = 0;
    while (lvl0 != 8'd100 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    led_pio_export = 8'h00;
    maxl  = 100;
    ups   = 0;
    downs = 0;
    prev  = 100;
    cyc   = 0;
    while (lvl0 != 8'd0 && cyc < 1000) begin
      step(1);
      cyc++;
      if (int'(lvl0) > prev) ups++;
      if (int'(lvl0) < prev) downs += prev - int'(lvl0);
      if (int'(lvl0) > maxl) maxl = int'(lvl0);
      prev = int'(lvl0);
    end
    check_eq("rev_max_level", 32'(maxl), 100);
    check_eq("rev_up_steps", 32'(ups), 0);
    check_eq("rev_down_steps", 32'(downs), 100);
    step(2);
    check_eq("rev_state_off", 32'(st0), 32'(ST_OFF));
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (led_out[0] !== 1'b0) cnt++;
    end
    check_eq("rev_led_off_highs", 32'(cnt), 0);

    // Bypass
    enable         = 1'b0;
    led_pio_export = 8'hA5;
    step(1);
    check_eq("byp_led_n1", 32'(led_out), 32'h00);
    step(1);
    check_eq("byp_led_n2", 32'(led_out), 32'hA5);
    check_eq("byp_busy", 32'(busy), 0);
    step(3);
    check_eq("byp_led_hold", 32'(led_out), 32'hA5);
    enable = 1'b1;
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (led_out !== 8'hA5) cnt++;
      if (busy !== 1'b0) cnt2++;
    end
    check_eq("byp_reenable_glitches", 32'(cnt), 0);
    check_eq("byp_reenable_busy", 32'(cnt2), 0);

    // Let all channels fade out, then reset asynchronously mid-ramp
    led_pio_export = 8'h00;
    step(4);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    step(2);
    check_eq("ar_pre_led_off", 32'(led_out), 32'h00);
    led_pio_export = 8'h01;
    cyc = 0;
    while (lvl0 != 8'd60 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    check_eq("ar_busy_before", 32'(busy), 1);
    #3;
    reset_reset_n = 1'b0;
    #1;
    check_eq("ar_led_async", 32'(led_out), 32'h00);
    check_eq("ar_busy_async", 32'(busy), 0);
    check_eq("ar_level_async", 32'(lvl0), 0);
    step(2);
    reset_reset_n = 1'b1;
    cyc   = 0;
    ups   = 0;
    downs = 0;
    prev  = 0;
    while (lvl0 != 8'd255 && cyc < 2000) begin
      step(1);
      cyc++;
      if (int'(lvl0) == prev + 1) ups++;
      else if (int'(lvl0) != prev) downs++;
      prev = int'(lvl0);
    end
    check_eq("ar_ramp_cycles_in_1016_1024", 32'(cyc >= 1016 && cyc <= 1024), 1);
    check_eq("ar_ramp_steps", 32'(ups), 255);
    check_eq("ar_ramp_bad_steps", 32'(downs), 0);
    step(2);
    check_eq("ar_busy_done", 32'(busy), 0);
    check_eq("ar_led_on", 32'(led_out), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
